// File: rtl/inst_axi_rbridge_if.sv
// Fetch-side SRAM-like request channel plus AXI read (AR/R) channel for the instruction bridge.
// The master modport is the bridge itself; slave is the fetch stage / AXI memory environment.
interface inst_axi_rbridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_bus_err;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_bus_err,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_bus_err,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rbridge.sv
// Instruction-fetch bridge: converts SRAM-like read requests into single-beat AXI reads,
// keeping up to MAX_OUTST requests in flight and returning data in request order.
module inst_axi_rbridge #(
  parameter logic [3:0]  ARID_VAL  = 4'h0,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               resetn,
  inst_axi_rbridge_if.master bus
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  ar_state_t         state;
  ar_state_t         state_nxt;
  logic [CNT_W-1:0]  outst_cnt;
  logic [CNT_W-1:0]  sent_cnt;
  logic [DATA_W-1:0] araddr_q;
  logic [2:0]        arsize_q;
  logic [DATA_W-1:0] rdata_q;
  logic              data_ok_q;
  logic              bus_err_q;

  logic              addr_ok_c;
  logic              arvalid_c;
  logic              ar_hs_c;
  logic              rready_c;
  logic              r_hs_c;
  logic              unused_ok;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= AR_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (addr_ok_c) state_nxt = AR_SEND;
      AR_SEND: if (ar_hs_c)   state_nxt = AR_IDLE;
      default: state_nxt = AR_IDLE;
    endcase
  end

  // Output decode: accept only in idle, with room for another outstanding read
  always_comb begin
    addr_ok_c = 1'b0;
    arvalid_c = 1'b0;
    case (state)
      AR_IDLE: addr_ok_c = bus.inst_sram_req & ~bus.inst_sram_wr &
                           (outst_cnt < CNT_W'(MAX_OUTST));
      AR_SEND: arvalid_c = 1'b1;
      default: begin
        addr_ok_c = 1'b0;
        arvalid_c = 1'b0;
      end
    endcase
  end

  assign ar_hs_c  = arvalid_c & bus.arready;
  assign rready_c = (outst_cnt != '0) && (sent_cnt != '0);
  assign r_hs_c   = bus.rvalid & rready_c;

  // Accepted-but-unreturned and sent-but-unreturned counters; +1/-1 together cancel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst_cnt <= '0;
      sent_cnt  <= '0;
    end else begin
      outst_cnt <= outst_cnt + CNT_W'(addr_ok_c) - CNT_W'(r_hs_c);
      sent_cnt  <= sent_cnt  + CNT_W'(ar_hs_c)   - CNT_W'(r_hs_c);
    end
  end

  // AR payload is captured at acceptance and held through AR_SEND
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr_q <= '0;
      arsize_q <= '0;
    end else if (addr_ok_c) begin
      araddr_q <= bus.inst_sram_addr;
      arsize_q <= {1'b0, bus.inst_sram_size};
    end
  end

  // R capture: data held until the next handshake, ok/err are one-cycle pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= '0;
      data_ok_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      data_ok_q <= r_hs_c;
      bus_err_q <= r_hs_c & (bus.rresp != 2'b00);
      if (r_hs_c) rdata_q <= bus.rdata;
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok_c;
  assign bus.inst_sram_data_ok = data_ok_q;
  assign bus.inst_sram_rdata   = rdata_q;
  assign bus.inst_bus_err      = bus_err_q;

  assign bus.arid    = ARID_VAL;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = arsize_q;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = arvalid_c;
  assign bus.rready  = rready_c;

  // Write payload and single-ID/single-beat R sideband carry no information here
  assign unused_ok = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rlast};

endmodule

// File: tb/tb_inst_axi_rbridge.sv
// Bench for inst_axi_rbridge: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of in-flight fetches.
module tb_inst_axi_rbridge;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [3:0]  ARID      = 4'h0;
  localparam logic [31:0] ERR_ADDR  = 32'h1c00_00f0;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  inst_axi_rbridge_if bus();

  inst_axi_rbridge #(.ARID_VAL(ARID), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // stimulus staging, applied at the next falling edge
  logic        s_rstn, s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;

  // AXI memory environment
  int unsigned ar_prob = 100;
  int unsigned rdly_min = 0, rdly_max = 0;
  bit          junk_en = 1'b0;
  logic [31:0] env_q[$];
  int          env_t[$];

  // behavioural model
  logic [31:0] infl_q[$];
  bit          m_busy;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arsize;
  bit          m_dok, m_err;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0c0c;
    if (a == ERR_ADDR)      return 32'hdead_beef;
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return (a == ERR_ADDR) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    infl_q.delete();
    m_busy = 1'b0; m_araddr = '0; m_arsize = '0;
    m_rdata = '0; m_dok = 1'b0; m_err = 1'b0;
  endtask

  // compare DUT against the model for this cycle, then advance the model over the edge
  task automatic compare();
    logic        e_aok, e_rready;
    logic [31:0] a;
    if (!resetn) model_clear();
    e_aok    = bus.inst_sram_req & ~bus.inst_sram_wr & ~m_busy &
               (infl_q.size() < int'(MAX_OUTST));
    e_rready = infl_q.size() > int'(m_busy);
    chk("addr_ok", bus.inst_sram_addr_ok, e_aok);
    chk("arvalid", bus.arvalid, m_busy);
    chk("araddr",  bus.araddr, m_araddr);
    chk("arsize",  bus.arsize, m_arsize);
    chk("rready",  bus.rready, e_rready);
    chk("data_ok", bus.inst_sram_data_ok, m_dok);
    chk("bus_err", bus.inst_bus_err, m_err);
    chk("rdata",   bus.inst_sram_rdata, m_rdata);
    if (resetn) begin
      m_dok = 1'b0; m_err = 1'b0;
      if (e_rready && bus.rvalid) begin
        a = infl_q.pop_front();
        m_dok = 1'b1; m_rdata = mem_data(a); m_err = (mem_resp(a) != 2'b00);
      end
      if (m_busy && bus.arready) m_busy = 1'b0;
      if (e_aok) begin
        m_busy = 1'b1; m_araddr = bus.inst_sram_addr;
        m_arsize = {1'b0, bus.inst_sram_size};
        infl_q.push_back(bus.inst_sram_addr);
      end
    end
  endtask

  task automatic step();
    bit due;
    @(negedge clk);
    cyc++;
    resetn              = s_rstn;
    bus.inst_sram_req   = s_req;
    bus.inst_sram_wr    = s_wr;
    bus.inst_sram_size  = s_size;
    bus.inst_sram_wstrb = s_wstrb;
    bus.inst_sram_addr  = s_addr;
    bus.inst_sram_wdata = s_wdata;
    bus.arready = ($urandom_range(99) < ar_prob);
    bus.rid     = 4'($urandom);
    bus.rlast   = 1'($urandom);
    due = (env_q.size() != 0) && (cyc >= env_t[0]);
    if (due) begin
      bus.rvalid = 1'b1; bus.rdata = mem_data(env_q[0]); bus.rresp = mem_resp(env_q[0]);
    end else begin
      bus.rvalid = (env_q.size() == 0) && junk_en && ($urandom_range(3) == 0);
      bus.rdata  = $urandom; bus.rresp = 2'($urandom);
    end
    #1;
    compare();
    if (!resetn) begin
      env_q.delete(); env_t.delete();
    end else begin
      if (due && bus.rready) begin
        void'(env_q.pop_front()); void'(env_t.pop_front());
      end
      if (bus.arvalid && bus.arready) begin
        env_q.push_back(bus.araddr);
        env_t.push_back(cyc + 1 + int'($urandom_range(rdly_max, rdly_min)));
      end
    end
  endtask

  task automatic set_req(input logic [31:0] addr);
    s_req = 1'b1; s_wr = 1'b0; s_size = 2'd2; s_addr = addr;
  endtask

  initial begin
    int          n_aok, n_rhs, n_dok, found;
    int          aok_c[3], rhs_c[3];
    logic [31:0] dv[3];

    s_rstn = 1'b0; s_req = 1'b0; s_wr = 1'b0; s_size = '0; s_wstrb = '0;
    s_addr = '0; s_wdata = '0;
    resetn = 1'b0; bus.inst_sram_req = 1'b0; bus.inst_sram_wr = 1'b0;
    bus.inst_sram_size = '0; bus.inst_sram_wstrb = '0; bus.inst_sram_addr = '0;
    bus.inst_sram_wdata = '0; bus.arready = 1'b0; bus.rid = '0; bus.rdata = '0;
    bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    model_clear();

    repeat (3) step();
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_rready",  bus.rready, 1'b0);
    chk("rst_rdata",   bus.inst_sram_rdata, 32'h0);
    chk("rst_araddr",  bus.araddr, 32'h0);

    // single fetch, minimum latency; request issued in the first cycle out of reset
    s_rstn = 1'b1;
    set_req(32'h1c00_0000);
    step();
    chk("t1_aok", bus.inst_sram_addr_ok, 1'b1);
    chk("c_arid", bus.arid, ARID);
    chk("c_arlen", bus.arlen, 8'd0);
    chk("c_arburst", bus.arburst, 2'b01);
    chk("c_misc", {bus.arlock, bus.arcache, bus.arprot}, 9'd0);
    s_req = 1'b0;
    step();
    chk("t1_arvalid", bus.arvalid, 1'b1);
    chk("t1_araddr", bus.araddr, 32'h1c00_0000);
    chk("t1_arsize", bus.arsize, 3'd2);
    step();
    chk("t1_rvalid_rready", {bus.rvalid, bus.rready}, 2'b11);
    step();
    chk("t1_dok", bus.inst_sram_data_ok, 1'b1);
    chk("t1_rdata", bus.inst_sram_rdata, 32'h0280_0c0c);
    step();
    chk("t1_dok_pulse", bus.inst_sram_data_ok, 1'b0);
    chk("t1_rdata_hold", bus.inst_sram_rdata, 32'h0280_0c0c);

    // AR backpressure for 4 cycles with the next request already waiting
    ar_prob = 0;
    set_req(32'h1c00_0040);
    step();
    s_addr = 32'h1c00_0044;
    repeat (4) begin
      step();
      chk("t2_arvalid", bus.arvalid, 1'b1);
      chk("t2_araddr", bus.araddr, 32'h1c00_0040);
      chk("t2_aok", bus.inst_sram_addr_ok, 1'b0);
    end
    ar_prob = 100;
    step();
    chk("t2_aok_hs", bus.inst_sram_addr_ok, 1'b0);
    step();
    chk("t2_aok_after", bus.inst_sram_addr_ok, 1'b1);
    s_req = 1'b0;
    repeat (8) step();

    // outstanding limit with R delayed 10 cycles
    rdly_min = 10; rdly_max = 10;
    n_aok = 0; n_rhs = 0; n_dok = 0;
    aok_c = '{-1, -1, -1}; rhs_c = '{-1, -1, -1}; dv = '{32'h0, 32'h0, 32'h0};
    set_req(32'h1c00_0000);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.rvalid && bus.rready && n_rhs < 3) begin rhs_c[n_rhs] = cyc; n_rhs++; end
      if (bus.inst_sram_data_ok && n_dok < 3) begin dv[n_dok] = bus.inst_sram_rdata; n_dok++; end
      if (bus.inst_sram_addr_ok && n_aok < 3) begin
        aok_c[n_aok] = cyc; n_aok++;
        if (n_aok < 3) s_addr = 32'h1c00_0000 + 32'(4 * n_aok);
        else s_req = 1'b0;
      end
    end
    chk("t3_n_aok", 32'(n_aok), 32'd3);
    chk("t3_n_dok", 32'(n_dok), 32'd3);
    chk("t3_aok1_gap", 32'(aok_c[1] - aok_c[0]), 32'd2);
    chk("t3_aok2_after_r", 32'(aok_c[2]), 32'(rhs_c[0] + 1));
    chk("t3_d0", dv[0], 32'h0280_0c0c);
    chk("t3_d1", dv[1], mem_data(32'h1c00_0004));
    chk("t3_d2", dv[2], mem_data(32'h1c00_0008));

    // error response still returns data
    rdly_min = 0; rdly_max = 0;
    set_req(ERR_ADDR);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      s_req = 1'b0;
      if (bus.inst_sram_data_ok) begin
        found++;
        chk("t4_err", bus.inst_bus_err, 1'b1);
        chk("t4_rdata", bus.inst_sram_rdata, 32'hdead_beef);
      end
    end
    chk("t4_found", 32'(found), 32'd1);

    // reset while a request awaits R; stray rvalid afterwards must be ignored
    rdly_min = 20; rdly_max = 20; junk_en = 1'b1;
    set_req(32'h1c00_0080);
    step();
    s_req = 1'b0;
    repeat (3) step();
    s_rstn = 1'b0;
    repeat (2) begin
      step();
      chk("t5_rst_arvalid", bus.arvalid, 1'b0);
      chk("t5_rst_rready", bus.rready, 1'b0);
    end
    s_rstn = 1'b1; rdly_min = 0; rdly_max = 0;
    set_req(32'h1c00_0000);
    step();
    chk("t5_aok_first", bus.inst_sram_addr_ok, 1'b1);
    s_req = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.inst_sram_data_ok) begin
        found++;
        chk("t5_rdata", bus.inst_sram_rdata, 32'h0280_0c0c);
      end
    end
    chk("t5_n_dok", 32'(found), 32'd1);

    // write requests are never accepted
    s_req = 1'b1; s_wr = 1'b1; s_addr = 32'h1c00_0100; s_wstrb = 4'hf; s_wdata = 32'h1234_5678;
    repeat (5) begin
      step();
      chk("t6_aok", bus.inst_sram_addr_ok, 1'b0);
      chk("t6_arvalid", bus.arvalid, 1'b0);
    end
    s_req = 1'b0; s_wr = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        ar_prob = $urandom_range(100);
        rdly_max = $urandom_range(6);
      end
      s_rstn = ($urandom_range(599) != 0);
      step();
      if (s_req && (s_wr ? ($urandom_range(3) == 0) : bus.inst_sram_addr_ok)) s_req = 1'b0;
      if (!s_req && $urandom_range(2) != 0) begin
        s_req = 1'b1; s_wr = ($urandom_range(7) == 0); s_size = 2'($urandom);
        s_addr = {16'h1c00, 14'($urandom), 2'b00};
        s_wstrb = 4'($urandom); s_wdata = $urandom;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inst_axi_rbridge.md
INST_AXI_RBRIDGE -- requirements
Module: inst_axi_rbridge

Interface
Parameters:
REQ-001 The block SHALL have parameter ARID_VAL, default 4'h0, the AXI ID driven on every read request.
REQ-002 The block SHALL have parameter MAX_OUTST, default 2, the maximum number of accepted requests whose data has not yet returned (range 1..3).
Ports:
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port inst_sram_req, input, 1, request valid from the fetch stage.
REQ-006 The block SHALL have ports inst_sram_wr (input, 1), inst_sram_size (input, 2), inst_sram_wstrb (input, 4), inst_sram_addr (input, 32) and inst_sram_wdata (input, 32); these are the request fields.
REQ-007 The block SHALL have ports inst_sram_addr_ok (output, 1) and inst_sram_data_ok (output, 1); these are the request-accept and data-return pulses.
REQ-008 The block SHALL have port inst_sram_rdata, output, 32, the returned instruction word.
REQ-009 The block SHALL have the AXI AR ports arid (output, 4), araddr (output, 32), arlen (output, 8), arsize (output, 3), arburst (output, 2), arlock (output, 2), arcache (output, 4), arprot (output, 3), arvalid (output, 1) and arready (input, 1).
REQ-010 The block SHALL have the AXI R ports rid (input, 4), rdata (input, 32), rresp (input, 2), rlast (input, 1), rvalid (input, 1) and rready (output, 1).
REQ-011 The block SHALL have port inst_bus_err, output, 1, a one-cycle pulse that accompanies a data_ok whose rresp was nonzero.

Function
REQ-012 Constant outputs SHALL be: arid=ARID_VAL, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
REQ-013 The AR state machine SHALL have states AR_IDLE and AR_SEND.
REQ-014 In AR_IDLE, inst_sram_addr_ok SHALL equal inst_sram_req & ~inst_sram_wr & (outst_cnt < MAX_OUTST), combinationally in the same cycle.
REQ-015 On an addr_ok cycle the block SHALL latch addr and {1'b0,size} into araddr/arsize and go to AR_SEND; outst_cnt SHALL increment.
REQ-016 In AR_SEND, arvalid SHALL be 1, araddr/arsize SHALL be held stable, and addr_ok SHALL be 0; on arvalid&arready the state SHALL return to AR_IDLE.
REQ-017 Write requests (wr=1) SHALL never receive addr_ok; wstrb and wdata SHALL be ignored.
REQ-018 rready SHALL be 1 iff outst_cnt > 0 and the count of AR-sent-not-returned transactions is > 0.
REQ-019 On rvalid&rready, rdata SHALL be registered into inst_sram_rdata, and inst_sram_data_ok SHALL pulse 1 in the next cycle.
REQ-020 On that R handshake, outst_cnt SHALL decrement.
REQ-021 inst_bus_err SHALL pulse together with data_ok when the captured rresp != 0; the data SHALL still be returned.
REQ-022 inst_sram_rdata SHALL hold its last value until the next R handshake.
REQ-023 Data SHALL return in request order; rid and rlast SHALL be ignored (single-beat, single ID).
REQ-024 Minimum latency SHALL be: addr_ok at cycle T, arvalid at T+1, with arready at T+1 and rvalid at T+2, data_ok at T+3.
REQ-025 An increment and a decrement of outst_cnt in the same cycle SHALL leave it unchanged.
REQ-026 At outst_cnt == MAX_OUTST, addr_ok SHALL be held 0 until a data return.
REQ-027 rvalid while no transaction is outstanding SHALL be ignored: rready stays 0 and no data_ok is produced.

Reset
REQ-028 While resetn=0, asynchronously: state=AR_IDLE, arvalid=0, rready=0, outst_cnt=0, sent count=0, data_ok=0, inst_bus_err=0, inst_sram_rdata=0, araddr=0, arsize=0.
REQ-029 Reset asserted mid-transaction SHALL drop all outstanding transactions with no data_ok; after release, the first req SHALL be accepted in the first cycle with resetn=1.

Verification
REQ-030 Single fetch: req with addr=0x1c000000, size=2 at cycle T; arready=1; rvalid at T+2 with rdata=0x02800c0c -> addr_ok at T, arvalid/araddr=0x1c000000/arsize=2 at T+1, data_ok=1 and rdata=0x02800c0c at T+3.
REQ-031 AR backpressure: arready held 0 for 4 cycles -> arvalid stays 1 with araddr unchanged, addr_ok stays 0 until the handshake.
REQ-032 Outstanding limit (MAX_OUTST=2): three back-to-back reqs with R delayed 10 cycles -> third addr_ok withheld until the cycle after the first R handshake; data for addresses 0x1c000000, 0x1c000004 and 0x1c000008 returns in order.
REQ-033 Error response: rresp=2'b10 with rdata=0xdeadbeef -> data_ok and inst_bus_err both 1 in the same cycle, rdata=0xdeadbeef.
REQ-034 Reset mid-flight: resetn low for 2 cycles while one request awaits R -> arvalid=0, rready=0, no data_ok; a post-reset req at 0x1c000000 completes normally.
REQ-035 Write request: wr=1, req=1 held 5 cycles -> addr_ok=0 and arvalid=0 throughout.
